// File: rtl/tl_a_queue_if.sv
// TileLink A-channel queue bundle: producer (enq) side, consumer (deq) side
// and the occupancy count. The queue takes the slave view; whoever drives
// the producer and consumer sides takes the master view.
interface tl_a_queue_if #(
  parameter int DEPTH    = 2,
  parameter int ADDR_W   = 21,
  parameter int DATA_W   = 64,
  parameter int SOURCE_W = 7
);
  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  // Producer side
  logic                io_enq_valid;
  logic                io_enq_ready;
  logic [2:0]          io_enq_bits_opcode;
  logic [2:0]          io_enq_bits_param;
  logic [2:0]          io_enq_bits_size;
  logic [SOURCE_W-1:0] io_enq_bits_source;
  logic [ADDR_W-1:0]   io_enq_bits_address;
  logic [MASK_W-1:0]   io_enq_bits_mask;
  logic [DATA_W-1:0]   io_enq_bits_data;
  logic                io_enq_bits_corrupt;

  // Consumer side
  logic                io_deq_valid;
  logic                io_deq_ready;
  logic [2:0]          io_deq_bits_opcode;
  logic [2:0]          io_deq_bits_param;
  logic [2:0]          io_deq_bits_size;
  logic [SOURCE_W-1:0] io_deq_bits_source;
  logic [ADDR_W-1:0]   io_deq_bits_address;
  logic [MASK_W-1:0]   io_deq_bits_mask;
  logic [DATA_W-1:0]   io_deq_bits_data;
  logic                io_deq_bits_corrupt;

  // Occupancy
  logic [CNT_W-1:0]    io_count;

  modport slave (
    input  io_enq_valid, io_enq_bits_opcode, io_enq_bits_param, io_enq_bits_size,
           io_enq_bits_source, io_enq_bits_address, io_enq_bits_mask,
           io_enq_bits_data, io_enq_bits_corrupt, io_deq_ready,
    output io_enq_ready, io_deq_valid, io_deq_bits_opcode, io_deq_bits_param,
           io_deq_bits_size, io_deq_bits_source, io_deq_bits_address,
           io_deq_bits_mask, io_deq_bits_data, io_deq_bits_corrupt, io_count
  );

  modport master (
    output io_enq_valid, io_enq_bits_opcode, io_enq_bits_param, io_enq_bits_size,
           io_enq_bits_source, io_enq_bits_address, io_enq_bits_mask,
           io_enq_bits_data, io_enq_bits_corrupt, io_deq_ready,
    input  io_enq_ready, io_deq_valid, io_deq_bits_opcode, io_deq_bits_param,
           io_deq_bits_size, io_deq_bits_source, io_deq_bits_address,
           io_deq_bits_mask, io_deq_bits_data, io_deq_bits_corrupt, io_count
  );
endinterface

// File: rtl/tl_a_queue.sv
// Parametrised TileLink A-channel FIFO with occupancy count and optional
// flow-through (empty queue forwards the incoming beat combinationally) and
// pipe (full queue accepts a new beat in the cycle the head leaves) modes.
// Depth need not be a power of two: pointers wrap by explicit compare.
module tl_a_queue #(
  parameter int DEPTH    = 2,
  parameter int ADDR_W   = 21,
  parameter int DATA_W   = 64,
  parameter int SOURCE_W = 7,
  parameter int FLOW     = 0,
  parameter int PIPE     = 0
) (
  input  logic          clock,
  input  logic          reset,
  tl_a_queue_if.slave   bus
);
  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BEAT_W = 9 + SOURCE_W + ADDR_W + MASK_W + DATA_W + 1;

  localparam logic             FLOW_EN  = (FLOW != 0);
  localparam logic             PIPE_EN  = (PIPE != 0);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [BEAT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_enqPtr;
  logic [PTR_W-1:0]  r_deqPtr;
  logic              r_maybeFull;

  logic [BEAT_W-1:0] w_enqBeat;
  logic [BEAT_W-1:0] w_headBeat;
  logic [BEAT_W-1:0] w_outBeat;
  logic              w_ptrMatch;
  logic              w_empty;
  logic              w_full;
  logic              w_bypass;
  logic              w_doEnq;
  logic              w_doDeq;
  logic              w_write;
  logic              w_advance;
  logic [CNT_W-1:0]  w_count;

  assign w_enqBeat = {bus.io_enq_bits_opcode, bus.io_enq_bits_param,
                      bus.io_enq_bits_size, bus.io_enq_bits_source,
                      bus.io_enq_bits_address, bus.io_enq_bits_mask,
                      bus.io_enq_bits_data, bus.io_enq_bits_corrupt};

  assign w_headBeat = r_mem[r_deqPtr];

  // Equal pointers are ambiguous; maybe_full says which way they met.
  assign w_ptrMatch = (r_enqPtr == r_deqPtr);
  assign w_empty    = w_ptrMatch & ~r_maybeFull;
  assign w_full     = w_ptrMatch &  r_maybeFull;

  // Flow-through only applies while nothing is stored.
  assign w_bypass = FLOW_EN & w_empty;

  assign bus.io_enq_ready = ~w_full | (PIPE_EN & bus.io_deq_ready);
  assign bus.io_deq_valid = w_bypass ? bus.io_enq_valid : ~w_empty;
  assign w_outBeat        = w_bypass ? w_enqBeat : w_headBeat;

  assign {bus.io_deq_bits_opcode, bus.io_deq_bits_param,
          bus.io_deq_bits_size, bus.io_deq_bits_source,
          bus.io_deq_bits_address, bus.io_deq_bits_mask,
          bus.io_deq_bits_data, bus.io_deq_bits_corrupt} = w_outBeat;

  assign w_doEnq = bus.io_enq_valid & bus.io_enq_ready;
  assign w_doDeq = bus.io_deq_valid & bus.io_deq_ready;

  // A beat forwarded straight through is neither stored nor popped.
  assign w_write   = w_doEnq & ~(w_bypass & bus.io_deq_ready);
  assign w_advance = w_doDeq & ~w_bypass;

  // Occupancy from the pointer distance, with the wrapped case folded back
  // by DEPTH so the result never leaves the CNT_W range.
  always_comb begin
    w_count = CNT_W'(r_enqPtr) - CNT_W'(r_deqPtr);
    if (w_full) begin
      w_count = FULL_CNT;
    end else if (r_enqPtr < r_deqPtr) begin
      w_count = (FULL_CNT - CNT_W'(r_deqPtr)) + CNT_W'(r_enqPtr);
    end
  end

  assign bus.io_count = w_count;

  // Control state: pointers wrap at DEPTH-1 (constant 0 when DEPTH is 1)
  // and maybe_full follows whichever side moved alone.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_enqPtr    <= '0;
      r_deqPtr    <= '0;
      r_maybeFull <= 1'b0;
    end else begin
      if (w_write) begin
        r_enqPtr <= (r_enqPtr == LAST_PTR) ? '0 : r_enqPtr + PTR_W'(1);
      end
      if (w_advance) begin
        r_deqPtr <= (r_deqPtr == LAST_PTR) ? '0 : r_deqPtr + PTR_W'(1);
      end
      if (w_write != w_advance) begin
        r_maybeFull <= w_write;
      end
    end
  end

  // Beat storage is data only and is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (w_write) begin
      r_mem[r_enqPtr] <= w_enqBeat;
    end
  end
endmodule

// File: tb/tb_tl_a_queue.sv
// Scoreboard bench for tl_a_queue: five queues of different depth/mode are
// driven from one stimulus process; a behavioural model (occupancy counter
// plus a queue of expected beats per DUT) predicts handshakes and order.
module tb_tl_a_queue;
  localparam int NI = 5;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [2:0]  size;
    logic [6:0]  source;
    logic [20:0] address;
    logic [7:0]  mask;
    logic [63:0] data;
    logic        corrupt;
  } beat_t;

  // Per-instance configuration: q0 D4, q1 D3, q2 D2 flow+pipe, q3 D2, q4 D1 pipe
  function automatic int depOf(int k);
    case (k)
      0:       return 4;
      1:       return 3;
      2:       return 2;
      3:       return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int flowOf(int k);
    return (k == 2) ? 1 : 0;
  endfunction

  function automatic int pipeOf(int k);
    return (k == 2 || k == 4) ? 1 : 0;
  endfunction

  logic clock = 1'b0;
  logic reset = 1'b0;

  logic [NI-1:0] enqValid;
  logic [NI-1:0] deqReady;
  logic [NI-1:0] enqReadyOut;
  logic [NI-1:0] deqValidOut;
  beat_t         enqBeat    [NI];
  beat_t         deqBeatOut [NI];
  logic [3:0]    cntOut     [NI];

  beat_t         expQ [NI][$];
  int            mCnt [NI];
  logic [NI-1:0] mEnqFire;

  int nVec = 0;
  int nErr = 0;

  // Free-running clock
  always #5 clock = ~clock;

  for (genvar g = 0; g < NI; g++) begin : gq
    tl_a_queue_if #(.DEPTH(depOf(g)), .ADDR_W(21), .DATA_W(64), .SOURCE_W(7)) bus ();

    tl_a_queue #(
      .DEPTH(depOf(g)), .ADDR_W(21), .DATA_W(64), .SOURCE_W(7),
      .FLOW(flowOf(g)), .PIPE(pipeOf(g))
    ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus.slave)
    );

    assign bus.io_enq_valid        = enqValid[g];
    assign bus.io_enq_bits_opcode  = enqBeat[g].opcode;
    assign bus.io_enq_bits_param   = enqBeat[g].param;
    assign bus.io_enq_bits_size    = enqBeat[g].size;
    assign bus.io_enq_bits_source  = enqBeat[g].source;
    assign bus.io_enq_bits_address = enqBeat[g].address;
    assign bus.io_enq_bits_mask    = enqBeat[g].mask;
    assign bus.io_enq_bits_data    = enqBeat[g].data;
    assign bus.io_enq_bits_corrupt = enqBeat[g].corrupt;
    assign bus.io_deq_ready        = deqReady[g];

    assign enqReadyOut[g] = bus.io_enq_ready;
    assign deqValidOut[g] = bus.io_deq_valid;
    assign deqBeatOut[g]  = {bus.io_deq_bits_opcode, bus.io_deq_bits_param,
                             bus.io_deq_bits_size, bus.io_deq_bits_source,
                             bus.io_deq_bits_address, bus.io_deq_bits_mask,
                             bus.io_deq_bits_data, bus.io_deq_bits_corrupt};
    assign cntOut[g]      = 4'(bus.io_count);
  end

  function automatic beat_t randBeat();
    beat_t b;
    b.opcode  = 3'($urandom);
    b.param   = 3'($urandom);
    b.size    = 3'($urandom);
    b.source  = 7'($urandom);
    b.address = 21'($urandom);
    b.mask    = 8'($urandom);
    b.data    = {$urandom, $urandom};
    b.corrupt = 1'($urandom);
    return b;
  endfunction

  task automatic checkOutput(input string name, input int k,
                             input logic [127:0] act, input logic [127:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("[TB] FAIL %s q%0d: got %0h expected %0h", name, k, act, exp);
    end
  endtask

  // One clock with the current inputs: model predicts ready/valid/count,
  // accepted beats go to the scoreboard, occupancy updates at the edge.
  task automatic applyStimulus();
    logic [NI-1:0] expReady;
    logic [NI-1:0] expValid;
    logic [NI-1:0] deqFire;
    for (int k = 0; k < NI; k++) begin
      expReady[k] = (mCnt[k] < depOf(k)) || (pipeOf(k) != 0 && deqReady[k]);
      expValid[k] = (mCnt[k] > 0) || (flowOf(k) != 0 && enqValid[k]);
      mEnqFire[k] = enqValid[k] && expReady[k];
      deqFire[k]  = expValid[k] && deqReady[k];
      if (mEnqFire[k]) expQ[k].push_back(enqBeat[k]);
    end
    @(negedge clock);
    for (int k = 0; k < NI; k++) begin
      checkOutput("enq_ready", k, 128'(enqReadyOut[k]), 128'(expReady[k]));
      checkOutput("deq_valid", k, 128'(deqValidOut[k]), 128'(expValid[k]));
      checkOutput("count", k, 128'(cntOut[k]), 128'(mCnt[k]));
    end
    @(posedge clock);
    for (int k = 0; k < NI; k++) begin
      mCnt[k] = mCnt[k] + int'(mEnqFire[k]) - int'(deqFire[k]);
    end
    #1;
  endtask

  task automatic idleAll();
    enqValid = '0;
    deqReady = '0;
  endtask

  task automatic doReset();
    idleAll();
    reset = 1'b1;
    for (int k = 0; k < NI; k++) begin
      mCnt[k] = 0;
      expQ[k].delete();
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  // Monitor: every beat leaving a queue must be the oldest one the model holds
  always @(negedge clock) begin
    for (int k = 0; k < NI; k++) begin
      if (!reset && deqValidOut[k] && deqReady[k]) begin
        if (expQ[k].size() == 0) begin
          nVec++;
          nErr++;
          $display("[TB] FAIL deq_unexpected q%0d: got beat %0h expected none", k, deqBeatOut[k]);
        end else begin
          checkOutput("deq_beat", k, 128'(deqBeatOut[k]), 128'(expQ[k].pop_front()));
        end
      end
    end
  end

  initial begin
    int idx;
    int guard;
    idleAll();
    for (int k = 0; k < NI; k++) begin
      enqBeat[k] = '0;
      mCnt[k]    = 0;
    end

    // Reset applied before any clock edge
    #1 reset = 1'b1;
    #2;
    for (int k = 0; k < NI; k++) begin
      checkOutput("reset_enq_ready", k, 128'(enqReadyOut[k]), 128'(1));
      checkOutput("reset_deq_valid", k, 128'(deqValidOut[k]), 128'(0));
      checkOutput("reset_count", k, 128'(cntOut[k]), 128'(0));
    end
    doReset();

    // Fill q0 with four addresses, hold an extra beat while full, then drain
    for (int i = 0; i < 4; i++) begin
      enqBeat[0] = randBeat();
      enqBeat[0].address = 21'(16 * (i + 1));
      enqValid[0] = 1'b1;
      applyStimulus();
    end
    enqBeat[0] = randBeat();
    applyStimulus();
    enqValid[0] = 1'b0;
    deqReady[0] = 1'b1;
    repeat (4) applyStimulus();
    idleAll();
    applyStimulus();

    // q0 holding two beats: simultaneous enq and deq keeps the count
    for (int i = 0; i < 2; i++) begin
      enqBeat[0] = randBeat();
      enqValid[0] = 1'b1;
      applyStimulus();
    end
    enqBeat[0] = randBeat();
    deqReady[0] = 1'b1;
    applyStimulus();
    idleAll();
    applyStimulus();
    deqReady[0] = 1'b1;
    repeat (3) applyStimulus();
    idleAll();

    // Reset between edges with three beats stored in q0
    for (int i = 0; i < 3; i++) begin
      enqBeat[0] = randBeat();
      enqValid[0] = 1'b1;
      applyStimulus();
    end
    idleAll();
    #2 reset = 1'b1;
    #1;
    checkOutput("midreset_deq_valid", 0, 128'(deqValidOut[0]), 128'(0));
    checkOutput("midreset_enq_ready", 0, 128'(enqReadyOut[0]), 128'(1));
    checkOutput("midreset_count", 0, 128'(cntOut[0]), 128'(0));
    doReset();

    // q1 (depth 3) streams data 0..9 against random consumer backpressure
    idx = 0;
    guard = 0;
    while ((idx < 10 || mCnt[1] > 0) && guard < 300) begin
      enqValid[1] = (idx < 10);
      enqBeat[1] = randBeat();
      enqBeat[1].data = 64'(idx);
      deqReady[1] = 1'($urandom_range(0, 1));
      applyStimulus();
      if (mEnqFire[1]) idx++;
      guard++;
    end
    idleAll();
    checkOutput("wrap_done", 1, 128'(guard < 300), 128'(1));
    checkOutput("wrap_left", 1, 128'(expQ[1].size()), 128'(0));

    // Flow-through on empty q2: consumed same cycle, then stored when blocked
    doReset();
    enqBeat[2] = randBeat();
    enqBeat[2].data = 64'hDEAD;
    enqValid[2] = 1'b1;
    deqReady[2] = 1'b1;
    applyStimulus();
    idleAll();
    applyStimulus();
    enqBeat[2] = randBeat();
    enqBeat[2].data = 64'hDEAD;
    enqValid[2] = 1'b1;
    applyStimulus();
    idleAll();
    applyStimulus();
    deqReady[2] = 1'b1;
    applyStimulus();
    idleAll();

    // Full depth-2 queues: q2 (pipe) accepts during deq, q3 does not
    for (int i = 0; i < 2; i++) begin
      enqBeat[2] = randBeat();
      enqBeat[3] = randBeat();
      enqValid[2] = 1'b1;
      enqValid[3] = 1'b1;
      applyStimulus();
    end
    enqBeat[2] = randBeat();
    enqBeat[3] = randBeat();
    deqReady[2] = 1'b1;
    deqReady[3] = 1'b1;
    applyStimulus();
    idleAll();
    applyStimulus();
    deqReady = '1;
    repeat (3) applyStimulus();
    idleAll();

    // Random traffic on every queue, then drain
    doReset();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NI; k++) begin
        enqValid[k] = 1'($urandom_range(0, 1));
        deqReady[k] = ($urandom_range(0, 3) != 0);
        enqBeat[k]  = randBeat();
      end
      applyStimulus();
    end
    enqValid = '0;
    deqReady = '1;
    repeat (6) applyStimulus();
    idleAll();
    for (int k = 0; k < NI; k++) begin
      checkOutput("final_left", k, 128'(expQ[k].size()), 128'(0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule

// File: doc/tl_a_queue.md
# tl_a_queue

Parametrised TileLink A-channel FIFO: buffers opcode/param/size/source/address/mask/data/corrupt beats between a producer and consumer with ready/valid handshakes on both sides. It generalises the fixed 2-entry A-channel queue to configurable depth and payload widths, adds an occupancy count, and adds optional flow-through and pipe modes. It sits on TileLink crossbar/bridge edges wherever a decoupling buffer is needed.

## Interface
- DEPTH, 2, number of entries; any integer ≥1 (not restricted to powers of two)
- ADDR_W, 21, address width
- DATA_W, 64, data width; multiple of 8; mask width MASK_W = DATA_W/8
- SOURCE_W, 7, source ID width
- FLOW, 0, 1 = empty queue passes enq beat to deq in the same cycle
- PIPE, 0, 1 = full queue accepts enq in the same cycle a deq fires
- CNT_W, derived = clog2(DEPTH+1), width of io_count
- clock  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all control state immediately
- io_enq_valid  input  1  producer beat valid
- io_enq_ready  output  1  queue can accept beat
- io_enq_bits_opcode / _param / _size  input  3 each  TileLink A fields
- io_enq_bits_source  input  SOURCE_W  source ID
- io_enq_bits_address  input  ADDR_W  address
- io_enq_bits_mask  input  MASK_W  byte mask
- io_enq_bits_data  input  DATA_W  data
- io_enq_bits_corrupt  input  1  corrupt flag
- io_deq_ready  input  1  consumer ready
- io_deq_valid  output  1  head beat valid
- io_deq_bits_*  output  same widths as enq  head beat fields
- io_count  output  CNT_W  entries currently stored (0..DEPTH)

## Operation
- Storage: DEPTH entries of the full concatenated beat; write pointer enq_ptr, read pointer deq_ptr, each 0..DEPTH-1, plus maybe_full flag.
- ptr_match = (enq_ptr == deq_ptr); empty = ptr_match & ~maybe_full; full = ptr_match & maybe_full.
- Base handshake: io_enq_ready = ~full; io_deq_valid = ~empty; do_enq = io_enq_valid & io_enq_ready; do_deq = io_deq_valid & io_deq_ready.
- do_enq: entry[enq_ptr] ← enq bits; enq_ptr advances; wraps from DEPTH-1 to 0 (explicit compare, not modulo-by-width).
- do_deq: deq_ptr advances with same wrap rule.
- maybe_full ← do_enq when do_enq ≠ do_deq; otherwise unchanged.
- io_deq_bits_* = entry[deq_ptr], combinational read; contents undefined (not checked) while io_deq_valid=0 except in FLOW bypass.
- FLOW=1: when empty, io_deq_valid = io_enq_valid and io_deq_bits_* = io_enq_bits_*; if io_deq_ready also high, the beat is consumed directly: no write, no pointer movement, count stays 0.
- PIPE=1: io_enq_ready = ~full | io_deq_ready; when full with simultaneous enq and deq, both fire, count stays DEPTH.
- io_count = maybe_full&ptr_match ? DEPTH : (enq_ptr − deq_ptr) mod DEPTH, computed without overflow in CNT_W bits.
- Simultaneous enq+deq in non-empty, non-full state: both fire, count unchanged.
- Enq when full (PIPE=0) or deq when empty (FLOW=0): no effect on state.
- DEPTH=1: pointers are constant 0; maybe_full alone encodes occupancy.

## Timing
- Reset (async assert): enq_ptr=0, deq_ptr=0, maybe_full=0 → io_enq_ready=1, io_deq_valid=0, io_count=0 without waiting for a clock edge. Storage array not reset. Reset mid-transfer discards all stored beats.
- Reset deassertion is synchronised externally; first accepted enq on the first rising edge with reset low.
- Latency: enq-to-deq-valid 1 cycle (FLOW=0); 0 cycles when empty with FLOW=1.
- io_enq_ready depends combinationally on io_deq_ready only when PIPE=1; io_deq_valid/bits depend combinationally on enq inputs only when FLOW=1.
- Throughput: one beat per cycle sustained for DEPTH≥2, or for DEPTH=1 with PIPE=1.

## Test plan
- Reset: DEPTH=4, assert reset mid-cycle with 3 beats stored → io_deq_valid=0, io_enq_ready=1, io_count=0 immediately, before next edge.
- Fill/drain: DEPTH=4, enq addresses 0x10,0x20,0x30,0x40 with deq_ready=0 → io_count 1,2,3,4, io_enq_ready=0 after 4th; drain → addresses emerge in order, io_count 3..0.
- Wrap: DEPTH=3 (non-power-of-2), stream 10 beats data=i with random deq_ready → output data 0..9 in order, no loss/duplication, io_count never >3.
- Simultaneous: DEPTH=4 holding 2 beats, enq+deq same cycle → io_count stays 2, head advances to next beat.
- FLOW=1: empty queue, enq_valid=1 data=0xDEAD, deq_ready=1 → io_deq_valid=1 and data=0xDEAD same cycle, io_count stays 0; with deq_ready=0 beat stored, count 1.
- PIPE=1: DEPTH=2 full, enq_valid=1 and deq_ready=1 → io_enq_ready=1, both fire, count remains 2; same with PIPE=0 → io_enq_ready=0, count 1.
